dmem_responder: RTL and testbench

Block-addressed data-memory model that sits on the memory side of the data-cache controller and answers its refill and writeback traffic. It accepts one block read or block write at a time, waits a programmable latency, then completes the transfer with a one-cycle `ready` (read) or `done` (write) pulse. It is the responder end of the controller's `memRen`/`memWen`/`memBlockAddr`/`memDin` → `memReadReady`/`memWriteDone`/`memDout` interface, and it is used both as the simulation main memory and as a bench stimulus source for cache tests.

---
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Block-addressed data-memory model: accepts one block read or write at a time,
// waits a programmable latency, then completes with a one-cycle ready/done pulse.
module dmem_responder #(
  parameter int ADDR_W        = 10,
  parameter int BLOCK_BITS    = 128,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter     INIT_FILE     = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     block_address,
  input  logic [BLOCK_BITS-1:0] din,
  output logic                  ready,
  output logic                  done,
  output logic [BLOCK_BITS-1:0] dout
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_RD,
    BUSY_WR,
    RELEASE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [BLOCK_BITS-1:0] din_q;
  logic [BLOCK_BITS-1:0] mem [DEPTH];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  commit;

  always_comb begin
    in_range = ({1'b0, addr_q} < DEPTH_LIM);
    idx      = addr_q[IDX_W-1:0];
    commit   = (state == BUSY_WR) && (cnt == '0) && in_range;
  end

  // The array has no reset; a reset forces IDLE, so an in-flight write never commits.
  always_ff @(posedge clock) begin
    if (commit) mem[idx] <= din_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      din_q  <= '0;
      ready  <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      ready <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (wen) begin
            state  <= BUSY_WR;
            addr_q <= block_address;
            din_q  <= din;
            cnt    <= CNT_W'(WRITE_LATENCY - 1);
          end else if (ren) begin
            state  <= BUSY_RD;
            addr_q <= block_address;
            cnt    <= CNT_W'(READ_LATENCY - 1);
          end
        end
        BUSY_RD: begin
          if (cnt == '0) begin
            dout  <= in_range ? mem[idx] : '0;
            ready <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BUSY_WR: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!ren && !wen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (full-depth, and DEPTH=1000 with
// unit read latency) driven by one linear sequence, checked against a scoreboard.
module tb_dmem_responder;
  localparam int AW = 10;
  localparam int BW = 128;
  localparam int DEP  [2] = '{1024, 1000};
  localparam int RLAT [2] = '{4, 1};
  localparam int WLAT [2] = '{3, 4};

  typedef struct {
    bit            is_wr;
    logic [BW-1:0] data;
    int            lat;
  } exp_t;

  logic          clock = 1'b0;
  logic [1:0]    rst = 2'b11;
  logic [1:0]    ren = 2'b00;
  logic [1:0]    wen = 2'b00;
  logic [1:0]    rdy;
  logic [1:0]    dn;
  logic [AW-1:0] addr [2];
  logic [BW-1:0] din  [2];
  logic [BW-1:0] dout [2];

  exp_t          sb[$];
  logic [BW-1:0] mdl [int];
  int            tests = 0;
  int            fails = 0;

  localparam logic [BW-1:0] PAT_A5   = {16{8'hA5}};
  localparam logic [BW-1:0] PAT_DEAD = {8{16'hDEAD}};
  localparam logic [BW-1:0] PAT_W9   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(AW), .BLOCK_BITS(BW), .DEPTH(1024),
                   .READ_LATENCY(4), .WRITE_LATENCY(3)) dut0 (
    .clock(clock), .reset(rst[0]), .ren(ren[0]), .wen(wen[0]),
    .block_address(addr[0]), .din(din[0]),
    .ready(rdy[0]), .done(dn[0]), .dout(dout[0])
  );

  dmem_responder #(.ADDR_W(AW), .BLOCK_BITS(BW), .DEPTH(1000),
                   .READ_LATENCY(1), .WRITE_LATENCY(4)) dut1 (
    .clock(clock), .reset(rst[1]), .ren(ren[1]), .wen(wen[1]),
    .block_address(addr[1]), .din(din[1]),
    .ready(rdy[1]), .done(dn[1]), .dout(dout[1])
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One request on instance w; inputs are scrambled right after acceptance so only the
  // latched copies can produce the right answer. rel_rst releases that instance's reset
  // in the same cycle the request is presented.
  task automatic txn(input int w, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [BW-1:0] d, input int hold, input bit rel_rst,
                     input string tag);
    exp_t e;
    int   k;
    bit   seen;
    int   key;
    key = w * 4096 + int'(a);
    e.is_wr = wr;
    e.lat   = wr ? WLAT[w] : RLAT[w];
    if (wr) begin
      e.data = d;
      if (int'(a) < DEP[w]) mdl[key] = d;
    end else if (int'(a) >= DEP[w]) begin
      e.data = '0;
    end else begin
      e.data = mdl.exists(key) ? mdl[key] : 'x;
    end
    sb.push_back(e);
    @(negedge clock);
    ren[w] = rd; wen[w] = wr; addr[w] = a; din[w] = d;
    if (rel_rst) rst[w] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    addr[w] = ~a; din[w] = ~d;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(posedge clock); #1;
      k++;
      if (rdy[w] || dn[w]) seen = 1'b1;
    end
    e = sb.pop_front();
    check({tag, " latency"}, BW'(k), BW'(e.lat));
    check({tag, " pulse"}, BW'({rdy[w], dn[w]}), e.is_wr ? BW'(2'b01) : BW'(2'b10));
    if (!e.is_wr) check({tag, " dout"}, dout[w], e.data);
    repeat (hold + 1) begin
      @(posedge clock); #1;
      check({tag, " single pulse"}, BW'({rdy[w], dn[w]}), BW'(2'b00));
    end
    @(negedge clock);
    ren[w] = 1'b0; wen[w] = 1'b0;
  endtask

  initial begin
    addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset ready/done 0", BW'({rdy, dn}), BW'(4'b0000));
    check("reset dout0", dout[0], '0);
    check("reset dout1", dout[1], '0);
    @(negedge clock);
    rst = 2'b00;

    // Instance 0: latency 4 read / 3 write, full depth
    txn(0, 0, 1, 10'd5, PAT_A5, 0, 0, "wr5");
    @(negedge clock); rst[0] = 1'b1;
    @(negedge clock); rst[0] = 1'b0;
    txn(0, 1, 0, 10'd5, '0, 0, 0, "rd5 after reset");
    repeat (3) @(posedge clock);
    #1;
    check("rd5 dout holds", dout[0], PAT_A5);
    txn(0, 0, 1, 10'd9, PAT_W9, 0, 0, "wr9");
    txn(0, 1, 0, 10'd9, '0, 0, 0, "rd9");
    txn(0, 1, 1, 10'd2, {4{32'h2222_1111}}, 0, 0, "ren+wen addr2");
    txn(0, 1, 0, 10'd2, '0, 0, 0, "rd2");
    txn(0, 1, 0, 10'd9, '0, 3, 0, "rd9 held");
    txn(0, 1, 0, 10'd5, '0, 0, 0, "rd5 after drop");
    txn(0, 0, 1, 10'd1023, {4{32'h3FF0_3FF0}}, 0, 0, "wr1023");
    txn(0, 1, 0, 10'd1023, '0, 0, 0, "rd1023");

    // Reset during a read with the request held: the held request restarts cleanly
    @(negedge clock);
    ren[0] = 1'b1; addr[0] = 10'd9;
    repeat (3) @(posedge clock);
    #1 rst[0] = 1'b1;
    #1;
    check("mid-read reset pulses", BW'({rdy[0], dn[0]}), BW'(2'b00));
    check("mid-read reset dout", dout[0], '0);
    txn(0, 1, 0, 10'd5, '0, 0, 1, "rd5 held thru reset");

    // Instance 1: DEPTH=1000, latency 1 read / 4 write
    txn(1, 0, 1, 10'd7, PAT_DEAD, 0, 0, "u1 wr7");
    txn(1, 1, 0, 10'd7, '0, 0, 0, "u1 rd7");
    @(negedge clock);
    wen[1] = 1'b1; addr[1] = 10'd7; din[1] = {4{32'hBEEF_0007}};
    @(posedge clock);
    @(posedge clock);
    #1 rst[1] = 1'b1;
    #1;
    check("mid-write reset dout", dout[1], '0);
    @(negedge clock); wen[1] = 1'b0;
    @(negedge clock); rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("no done after reset", BW'(dn[1]), BW'(1'b0));
    end
    txn(1, 1, 0, 10'd7, '0, 0, 0, "u1 rd7 after aborted wr");
    txn(1, 1, 0, 10'd1010, '0, 0, 0, "u1 rd oob");
    txn(1, 0, 1, 10'd1010, {4{32'h0BAD_0BAD}}, 0, 0, "u1 wr oob");
    txn(1, 1, 0, 10'd1010, '0, 0, 0, "u1 rd oob again");
    txn(1, 0, 1, 10'd999, {4{32'h0999_0999}}, 0, 0, "u1 wr999");
    txn(1, 1, 0, 10'd999, '0, 0, 0, "u1 rd999");

    check("scoreboard drained", BW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
